// File: rtl/button_event_decoder.sv
// button_event_decoder
// Classifies presses of a debounced switch into SINGLE, DOUBLE and LONG events.
// Events are queued in a 2-entry FIFO with a valid/ready consumer handshake.
// A sticky ovf flag records any event that was dropped because the FIFO was full.
module button_event_decoder #(
   parameter int LONG_TIME   = 1000,
   parameter int DCLICK_TIME = 500,
   parameter int CW          = 23
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       sw_db,
   input  logic       evt_ready,
   input  logic       clr_ovf,
   output logic       evt_valid,
   output logic [1:0] evt_code,
   output logic       ovf,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE           = 3'd0,
      ST_PRESSED        = 3'd1,
      ST_LONG_HELD      = 3'd2,
      ST_WAIT_SECOND    = 3'd3,
      ST_SECOND_PRESSED = 3'd4
   } state_t;

   localparam logic [1:0]    EVT_NONE    = 2'b00;
   localparam logic [1:0]    EVT_SINGLE  = 2'b01;
   localparam logic [1:0]    EVT_DOUBLE  = 2'b10;
   localparam logic [1:0]    EVT_LONG    = 2'b11;
   localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
   localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TIME - 1);
   localparam logic [CW-1:0] DCLICK_LAST = CW'(DCLICK_TIME - 1);

   // Saturating increment keeps the timer from wrapping during very long holds.
   function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
      if (c == CNT_MAX) begin
         cnt_inc = c;
      end else begin
         cnt_inc = c + CNT_ONE;
      end
   endfunction

   state_t        state_r;
   logic [CW-1:0] cnt_r;
   logic          sw_q_r;
   logic [1:0]    slot0_r;
   logic [1:0]    slot1_r;
   logic [1:0]    count_r;
   logic          evt_valid_r;
   logic [1:0]    evt_code_r;
   logic          ovf_r;
   logic          busy_r;

   logic          rise_s;
   logic          fall_s;
   logic          long_hit_s;
   logic          single_hit_s;
   logic          double_hit_s;
   logic          push_s;
   logic [1:0]    push_code_s;
   logic          pop_s;
   logic          drop_s;
   logic [1:0]    slot0_nxt_s;
   logic [1:0]    slot1_nxt_s;
   logic [1:0]    count_nxt_s;

   assign rise_s = sw_db & ~sw_q_r;
   assign fall_s = ~sw_db & sw_q_r;

   // Event-producing transitions; shared by the FSM and the FIFO push so both agree.
   // A rise in WAIT_SECOND takes priority over the double-click timeout.
   assign long_hit_s   = (state_r == ST_PRESSED) & sw_db & (cnt_r == LONG_LAST);
   assign single_hit_s = (state_r == ST_WAIT_SECOND) & ~rise_s & (cnt_r == DCLICK_LAST);
   assign double_hit_s = (state_r == ST_SECOND_PRESSED) & fall_s;

   // Select the event code pushed by the current transition, if any.
   always_comb begin
      push_s      = 1'b0;
      push_code_s = EVT_NONE;
      if (long_hit_s) begin
         push_s      = 1'b1;
         push_code_s = EVT_LONG;
      end else if (single_hit_s) begin
         push_s      = 1'b1;
         push_code_s = EVT_SINGLE;
      end else if (double_hit_s) begin
         push_s      = 1'b1;
         push_code_s = EVT_DOUBLE;
      end else begin
         push_s      = 1'b0;
         push_code_s = EVT_NONE;
      end
   end

   // Gesture FSM with the press/gap timer and registered busy flag.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         sw_q_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         sw_q_r <= sw_db;
         case (state_r)
            ST_IDLE: begin
               cnt_r <= CNT_ZERO;
               if (rise_s) begin
                  state_r <= ST_PRESSED;
                  busy_r  <= 1'b1;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            ST_PRESSED: begin
               if (fall_s) begin
                  state_r <= ST_WAIT_SECOND;
                  cnt_r   <= CNT_ZERO;
               end else if (long_hit_s) begin
                  state_r <= ST_LONG_HELD;
                  cnt_r   <= CNT_ZERO;
               end else begin
                  cnt_r   <= cnt_inc(cnt_r);
               end
               busy_r <= 1'b1;
            end
            ST_LONG_HELD: begin
               cnt_r <= CNT_ZERO;
               if (fall_s) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  busy_r  <= 1'b1;
               end
            end
            ST_WAIT_SECOND: begin
               if (rise_s) begin
                  state_r <= ST_SECOND_PRESSED;
                  cnt_r   <= CNT_ZERO;
                  busy_r  <= 1'b1;
               end else if (single_hit_s) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= CNT_ZERO;
                  busy_r  <= 1'b0;
               end else begin
                  cnt_r   <= cnt_inc(cnt_r);
                  busy_r  <= 1'b1;
               end
            end
            ST_SECOND_PRESSED: begin
               cnt_r <= CNT_ZERO;
               if (double_hit_s) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  busy_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= CNT_ZERO;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign pop_s = evt_valid_r & evt_ready;

   // Next FIFO contents: slot0 is the head; a push at full without a pop is dropped.
   always_comb begin
      slot0_nxt_s = slot0_r;
      slot1_nxt_s = slot1_r;
      count_nxt_s = count_r;
      drop_s      = 1'b0;
      case (count_r)
         2'd0: begin
            if (push_s) begin
               slot0_nxt_s = push_code_s;
               count_nxt_s = 2'd1;
            end else begin
               count_nxt_s = 2'd0;
            end
         end
         2'd1: begin
            if (push_s && pop_s) begin
               slot0_nxt_s = push_code_s;
            end else if (push_s) begin
               slot1_nxt_s = push_code_s;
               count_nxt_s = 2'd2;
            end else if (pop_s) begin
               count_nxt_s = 2'd0;
            end else begin
               count_nxt_s = 2'd1;
            end
         end
         2'd2: begin
            if (push_s && pop_s) begin
               slot0_nxt_s = slot1_r;
               slot1_nxt_s = push_code_s;
            end else if (pop_s) begin
               slot0_nxt_s = slot1_r;
               count_nxt_s = 2'd1;
            end else if (push_s) begin
               drop_s      = 1'b1;
            end else begin
               count_nxt_s = 2'd2;
            end
         end
         default: begin
            count_nxt_s = 2'd0;
         end
      endcase
   end

   // FIFO storage, registered head outputs and sticky overflow (a new drop beats clear).
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         slot0_r     <= EVT_NONE;
         slot1_r     <= EVT_NONE;
         count_r     <= 2'd0;
         evt_valid_r <= 1'b0;
         evt_code_r  <= EVT_NONE;
         ovf_r       <= 1'b0;
      end else begin
         slot0_r     <= slot0_nxt_s;
         slot1_r     <= slot1_nxt_s;
         count_r     <= count_nxt_s;
         evt_valid_r <= (count_nxt_s != 2'd0);
         evt_code_r  <= (count_nxt_s != 2'd0) ? slot0_nxt_s : EVT_NONE;
         if (drop_s) begin
            ovf_r <= 1'b1;
         end else if (clr_ovf) begin
            ovf_r <= 1'b0;
         end else begin
            ovf_r <= ovf_r;
         end
      end
   end

   assign evt_valid = evt_valid_r;
   assign evt_code  = evt_code_r;
   assign ovf       = ovf_r;
   assign busy      = busy_r;

endmodule
